// File: rtl/cnn_pkg.sv
// Shared types and arithmetic helpers for the sequential CNN layers.
package cnn_pkg;

   typedef enum logic [1:0] {IDLE, MAC, QUANT, DONE} fc_state_e;

   // Working width used by sat_shift, wide enough for any accumulator in use.
   localparam int unsigned SAT_W = 64;

   // Accumulator width that cannot overflow for n signed w-by-w products.
   function automatic int unsigned acc_width(int unsigned w, int unsigned n);
      return 2 * w + $clog2(n);
   endfunction

   // Arithmetic right shift, then clamp to the signed range of 'width' bits.
   function automatic logic signed [31:0] sat_shift(logic signed [SAT_W-1:0] acc,
                                                    int unsigned shift, int unsigned width);
      logic signed [SAT_W-1:0] r, hi, lo;
      r  = acc >>> shift;
      hi = (64'sd1 <<< (width - 1)) - 64'sd1;
      lo = -hi - 64'sd1;
      if (r > hi) begin
         r = hi;
      end else if (r < lo) begin
         r = lo;
      end
      return 32'(r);
   endfunction

endpackage

// File: rtl/fc_mac_lane.sv
// One signed multiply-accumulate lane; clear wins over enable.
module fc_mac_lane #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned ACC_W = 18
) (
   input  logic                    clk_i,
   input  logic                    rst_ni,
   input  logic                    clr_i,
   input  logic                    en_i,
   input  logic [WIDTH-1:0]        w_i,
   input  logic [WIDTH-1:0]        x_i,
   output logic signed [ACC_W-1:0] acc_o
);

   logic signed [2*WIDTH-1:0] prod;
   logic signed [ACC_W-1:0]   acc_d, acc_q;

   // Signed product sign-extended into the accumulator.
   always_comb begin
      prod  = $signed(w_i) * $signed(x_i);
      acc_d = acc_q;
      if (clr_i) begin
         acc_d = '0;
      end else if (en_i) begin
         acc_d = acc_q + ACC_W'(prod);
      end
   end

   // Accumulator register.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         acc_q <= '0;
      end else begin
         acc_q <= acc_d;
      end
   end

   assign acc_o = acc_q;

endmodule

// File: rtl/fc_seq_layer.sv
// Time-multiplexed fully-connected layer: LANES neurons per group, one input per cycle.
module fc_seq_layer
   import cnn_pkg::*;
#(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned N_IN  = 256,
   parameter int unsigned N_OUT = 128,
   parameter int unsigned LANES = 4,
   parameter int unsigned SHIFT = 11,
   parameter int unsigned RELU  = 1,
   localparam int unsigned G    = (N_OUT + LANES - 1) / LANES,
   localparam int unsigned AW   = (G * N_IN > 1) ? $clog2(G * N_IN) : 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] x [0:N_IN-1],
   output logic [AW-1:0]    w_addr,
   input  logic [WIDTH-1:0] w_data [0:LANES-1],
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] z [0:N_OUT-1]
);

   localparam int unsigned ACC_W = acc_width(WIDTH, N_IN);
   localparam int unsigned KW    = $clog2(N_IN + 1);
   localparam int unsigned XW    = (N_IN > 1) ? $clog2(N_IN) : 1;
   localparam int unsigned GW    = (G > 1) ? $clog2(G) : 1;

   fc_state_e               state_q, state_d;
   logic [KW-1:0]           k_q;
   logic [GW-1:0]           g_q;
   logic [AW-1:0]           w_addr_q;
   logic [WIDTH-1:0]        x_q [N_IN];
   logic [WIDTH-1:0]        z_q [N_OUT];
   logic [XW-1:0]           x_idx;
   logic [WIDTH-1:0]        x_sel;
   logic                    lane_clr, lane_en, last_k, last_g;
   logic signed [ACC_W-1:0] acc [LANES];
   logic [WIDTH-1:0]        q [LANES];

   // k counts address cycles 0..N_IN-1 plus one drain cycle at k == N_IN.
   assign last_k = (k_q == KW'(N_IN));
   assign last_g = (g_q == GW'(G - 1));
   // ROM data seen at step k belongs to input element k-1.
   assign x_idx  = XW'(k_q - KW'(1));
   assign x_sel  = x_q[x_idx];

   // Next-state and handshake outputs.
   always_comb begin
      state_d   = state_q;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      lane_clr  = 1'b0;
      lane_en   = 1'b0;
      case (state_q)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) state_d = MAC;
         end
         MAC: begin
            lane_clr = (k_q == '0);
            lane_en  = (k_q != '0);
            if (last_k) state_d = QUANT;
         end
         QUANT: state_d = last_g ? DONE : MAC;
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Group/step counters and the ROM address, which simply walks g*N_IN+k.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         k_q      <= '0;
         g_q      <= '0;
         w_addr_q <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (in_valid) begin
                  k_q      <= '0;
                  g_q      <= '0;
                  w_addr_q <= '0;
               end
            end
            MAC: begin
               k_q <= last_k ? '0 : k_q + KW'(1);
               if (k_q < KW'(N_IN - 1)) w_addr_q <= w_addr_q + AW'(1);
            end
            QUANT: begin
               if (!last_g) begin
                  g_q      <= g_q + GW'(1);
                  w_addr_q <= w_addr_q + AW'(1);
               end
            end
            default: ;
         endcase
      end
   end

   // Input vector capture on acceptance; upstream may change x afterwards.
   always_ff @(posedge clk) begin
      if (state_q == IDLE && in_valid) x_q <= x;
   end

   for (genvar l = 0; l < LANES; l++) begin : g_lane
      logic signed [31:0] sat;

      fc_mac_lane #(
         .WIDTH (WIDTH),
         .ACC_W (ACC_W)
      ) u_lane (
         .clk_i  (clk),
         .rst_ni (rst_n),
         .clr_i  (lane_clr),
         .en_i   (lane_en),
         .w_i    (w_data[l]),
         .x_i    (x_sel),
         .acc_o  (acc[l])
      );

      assign sat  = sat_shift(SAT_W'(acc[l]), SHIFT, WIDTH);
      assign q[l] = (RELU != 0 && sat < 0) ? '0 : WIDTH'(sat);
   end

   // Lanes past N_OUT in the last group have no neuron here and are dropped.
   for (genvar j = 0; j < N_OUT; j++) begin : g_z
      // Capture neuron j when its group is being quantised.
      always_ff @(posedge clk) begin
         if (!rst_n) begin
            z_q[j] <= '0;
         end else if (state_q == QUANT && g_q == GW'(j / LANES)) begin
            z_q[j] <= q[j % LANES];
         end
      end
   end

   assign w_addr = w_addr_q;
   assign z      = z_q;

endmodule

// File: tb/tb_fc_seq_layer.sv
// Bench for fc_seq_layer: three instances (SHIFT/RELU variants), ROM model, reference model.
`timescale 1ns/1ps
module tb_fc_seq_layer;

   localparam int ND = 3;
   localparam int SH [ND] = '{0, 0, 2};
   localparam int RL [ND] = '{1, 0, 1};

   logic       clk = 1'b0;
   logic       rst_n;
   logic       in_valid_v  [ND];
   logic       in_ready_v  [ND];
   logic       out_valid_v [ND];
   logic       out_ready_v [ND];
   logic [7:0] xv [ND][4];
   logic [7:0] wd [ND][4];
   logic [7:0] zv [ND][6];
   logic [2:0] wa [ND];
   logic [7:0] wmem [ND][6][4];

   int          checks = 0;
   int          failures = 0;
   int          cyc = 0;
   logic [47:0] exp_q [ND][$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   for (genvar d = 0; d < ND; d++) begin : g_dut
      fc_seq_layer #(
         .WIDTH (8),
         .N_IN  (4),
         .N_OUT (6),
         .LANES (4),
         .SHIFT (SH[d]),
         .RELU  (RL[d])
      ) u_dut (
         .clk       (clk),
         .rst_n     (rst_n),
         .in_valid  (in_valid_v[d]),
         .in_ready  (in_ready_v[d]),
         .x         (xv[d]),
         .w_addr    (wa[d]),
         .w_data    (wd[d]),
         .out_valid (out_valid_v[d]),
         .out_ready (out_ready_v[d]),
         .z         (zv[d])
      );
   end

   // Weight ROM word a holds W[(a/4)*4+l][a%4]; nonexistent neurons read junk.
   function automatic logic [7:0] rom_word(input int d, input int a, input int l);
      int j = (a / 4) * 4 + l;
      if (j >= 6) return 8'h5A;
      return wmem[d][j][a % 4];
   endfunction

   always @(posedge clk)
      for (int d = 0; d < ND; d++)
         for (int l = 0; l < 4; l++) wd[d][l] <= rom_word(d, int'(wa[d]), l);

   // Reference: plain integer dot products, shift, clamp, optional ReLU.
   function automatic logic [47:0] model(input int d);
      logic [47:0] r;
      int s, q;
      for (int j = 0; j < 6; j++) begin
         s = 0;
         for (int k = 0; k < 4; k++)
            s += int'($signed(wmem[d][j][k])) * int'($signed(xv[d][k]));
         q = s >>> SH[d];
         if (q > 127) q = 127;
         if (q < -128) q = -128;
         if (RL[d] != 0 && q < 0) q = 0;
         r[j*8 +: 8] = q[7:0];
      end
      return r;
   endfunction

   function automatic logic [47:0] zpk(input int d);
      logic [47:0] r;
      for (int j = 0; j < 6; j++) r[j*8 +: 8] = zv[d][j];
      return r;
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, req);
      end
   endtask

   // Scoreboard: enqueue the model result at each accept, check z whenever out_valid.
   always @(negedge clk) begin
      if (!rst_n) begin
         for (int d = 0; d < ND; d++) exp_q[d].delete();
      end else begin
         for (int d = 0; d < ND; d++) begin
            if (out_valid_v[d]) begin
               chk($sformatf("pending_result_%0d", d), 64'(exp_q[d].size() != 0), 64'd1);
               if (exp_q[d].size() != 0) begin
                  chk($sformatf("z_vs_model_%0d", d), 64'(zpk(d)), 64'(exp_q[d][0]));
                  if (out_ready_v[d]) void'(exp_q[d].pop_front());
               end
            end
            if (in_valid_v[d] && in_ready_v[d]) exp_q[d].push_back(model(d));
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_w(input int d, input logic [7:0] v);
      for (int j = 0; j < 6; j++)
         for (int k = 0; k < 4; k++) wmem[d][j][k] = v;
   endtask

   task automatic set_x(input int d, input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] c, input logic [7:0] e);
      xv[d][0] = a; xv[d][1] = b; xv[d][2] = c; xv[d][3] = e;
   endtask

   // Hold in_valid until accepted; c0 is the cycle count just after the accept edge.
   task automatic send(input int d, output int c0);
      bit got = 1'b0;
      in_valid_v[d] = 1'b1;
      for (int t = 0; t < 60 && !got; t++) begin
         @(negedge clk);
         if (in_ready_v[d]) got = 1'b1;
      end
      chk($sformatf("accept_%0d", d), 64'(got), 64'd1);
      tick();
      c0 = cyc;
      in_valid_v[d] = 1'b0;
   endtask

   task automatic wait_out(input int d, output int cv);
      bit got = 1'b0;
      for (int t = 0; t < 200 && !got; t++) begin
         @(negedge clk);
         if (out_valid_v[d]) got = 1'b1;
      end
      chk($sformatf("out_valid_seen_%0d", d), 64'(got), 64'd1);
      cv = cyc;
   endtask

   // Pin the model to a hand value, run one vector, check z and latency.
   task automatic run_lit(input int d, input string nm, input logic [47:0] req);
      int c0, cv;
      chk({nm, "_model"}, 64'(model(d)), 64'(req));
      send(d, c0);
      wait_out(d, cv);
      chk({nm, "_latency"}, 64'(cv - c0), 64'd12);
      chk({nm, "_z"}, 64'(zpk(d)), 64'(req));
      tick();
      tick();
   endtask

   task automatic rand_x(input int d);
      for (int k = 0; k < 4; k++) xv[d][k] = 8'($urandom);
   endtask

   // Continuous in_valid; each new accept must come two cycles after out_valid rises.
   task automatic b2b(input int d, input int n);
      int prev = 0, c;
      bit got;
      rand_x(d);
      in_valid_v[d] = 1'b1;
      for (int v = 0; v < n; v++) begin
         got = 1'b0;
         for (int t = 0; t < 60 && !got; t++) begin
            @(negedge clk);
            if (in_ready_v[d]) got = 1'b1;
         end
         chk($sformatf("b2b_accept_%0d", d), 64'(got), 64'd1);
         if (!got) break;
         tick();
         c = cyc;
         if (v > 0) chk($sformatf("b2b_interval_%0d", d), 64'(c - prev), 64'd14);
         prev = c;
         rand_x(d);
      end
      in_valid_v[d] = 1'b0;
      got = 1'b0;
      for (int t = 0; t < 100 && !got; t++) begin
         tick();
         if (exp_q[d].size() == 0) got = 1'b1;
      end
      chk($sformatf("b2b_drain_%0d", d), 64'(got), 64'd1);
   endtask

   initial begin
      int  c0, cv;
      bit  seen;
      rst_n = 1'b0;
      for (int d = 0; d < ND; d++) begin
         in_valid_v[d]  = 1'b0;
         out_ready_v[d] = 1'b1;
         set_x(d, 8'd0, 8'd0, 8'd0, 8'd0);
         set_w(d, 8'd0);
      end
      repeat (3) tick();
      for (int d = 0; d < ND; d++) begin
         chk($sformatf("rst_in_ready_%0d", d), 64'(in_ready_v[d]), 64'd1);
         chk($sformatf("rst_out_valid_%0d", d), 64'(out_valid_v[d]), 64'd0);
         chk($sformatf("rst_z_%0d", d), 64'(zpk(d)), 64'd0);
         chk($sformatf("rst_w_addr_%0d", d), 64'(wa[d]), 64'd0);
      end
      rst_n = 1'b1;
      tick();

      // Plain dot product across both groups.
      set_x(0, 8'd1, 8'd2, 8'd3, 8'd4);
      set_w(0, 8'd1);
      chk("t2_busy_model", 64'(model(0)), 64'h0a0a0a0a0a0a);
      send(0, c0);
      chk("t2_in_ready_busy", 64'(in_ready_v[0]), 64'd0);
      wait_out(0, cv);
      chk("t2_latency", 64'(cv - c0), 64'd12);
      chk("t2_z", 64'(zpk(0)), 64'h0a0a0a0a0a0a);
      tick();
      tick();

      // Reset in the middle of MAC aborts the vector and clears z.
      set_x(0, 8'd1, 8'd1, 8'd1, 8'd1);
      send(0, c0);
      tick();
      tick();
      rst_n = 1'b0;
      tick();
      chk("t1_out_valid", 64'(out_valid_v[0]), 64'd0);
      chk("t1_in_ready", 64'(in_ready_v[0]), 64'd1);
      chk("t1_z", 64'(zpk(0)), 64'd0);
      tick();
      tick();
      rst_n = 1'b1;
      tick();
      set_x(0, 8'd4, 8'd3, 8'd2, 8'd1);
      set_w(0, 8'd2);
      run_lit(0, "t1_fresh", 48'h141414141414);

      // Saturation both ways and ReLU.
      set_x(0, 8'd127, 8'd127, 8'd127, 8'd127);
      set_w(0, 8'd127);
      run_lit(0, "t3_sat_pos", 48'h7f7f7f7f7f7f);
      set_x(1, 8'd127, 8'd127, 8'd127, 8'd127);
      set_w(1, 8'h80);
      run_lit(1, "t3_sat_neg", 48'h808080808080);
      set_w(0, 8'h80);
      run_lit(0, "t3_relu", 48'h000000000000);

      // SHIFT=2 and the partial last group.
      set_x(2, 8'd5, 8'd0, 8'd0, 8'd0);
      set_w(2, 8'd9);
      for (int j = 0; j < 6; j++) wmem[2][j][0] = 8'(j + 1);
      run_lit(2, "t4_shift", 48'h070605030201);

      // Back-pressure: z and out_valid hold, in_valid pulse is ignored.
      out_ready_v[1] = 1'b0;
      set_x(1, 8'hff, 8'hfe, 8'hfd, 8'hfc);
      set_w(1, 8'd1);
      chk("t5_model", 64'(model(1)), 64'hf6f6f6f6f6f6);
      send(1, c0);
      wait_out(1, cv);
      for (int t = 0; t < 10; t++) begin
         tick();
         if (t == 3) begin
            set_x(1, 8'd7, 8'd7, 8'd7, 8'd7);
            in_valid_v[1] = 1'b1;
         end
         if (t == 4) in_valid_v[1] = 1'b0;
         chk("t5_out_valid_hold", 64'(out_valid_v[1]), 64'd1);
         chk("t5_in_ready_low", 64'(in_ready_v[1]), 64'd0);
         chk("t5_z_hold", 64'(zpk(1)), 64'hf6f6f6f6f6f6);
      end
      out_ready_v[1] = 1'b1;
      tick();
      chk("t5_released", 64'(out_valid_v[1]), 64'd0);
      chk("t5_idle_ready", 64'(in_ready_v[1]), 64'd1);
      seen = 1'b0;
      for (int t = 0; t < 20; t++) begin
         tick();
         if (out_valid_v[1]) seen = 1'b1;
      end
      chk("t5_no_late_accept", 64'(seen), 64'd0);
      chk("t5_z_kept_idle", 64'(zpk(1)), 64'hf6f6f6f6f6f6);

      // Back-to-back random vectors, weights reloaded per batch while idle.
      for (int b = 0; b < 5; b++) begin
         for (int d = 0; d < 2; d++)
            for (int j = 0; j < 6; j++)
               for (int k = 0; k < 4; k++) wmem[d][j][k] = 8'($urandom);
         fork
            b2b(0, 20);
            b2b(1, 20);
         join
      end

      for (int d = 0; d < ND; d++)
         chk($sformatf("final_queue_empty_%0d", d), 64'(exp_q[d].size()), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
